// File: rtl/data_axi_bridge_pkg.sv
// Shared types and helpers for the MEM-stage SRAM-to-AXI3 data bridge.
// Holds FSM states, AXI response codes and the size-to-axsize mapping.
package data_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4
  } state_t;

  localparam logic [1:0] OKAY = 2'b00;

  // SRAM size code to AXI AxSIZE; code 3 is clamped to a word.
  function automatic logic [2:0] axsize(input logic [1:0] size);
    logic [2:0] r;
    r = (size == 2'd3) ? 3'd2 : {1'b0, size};
    return r;
  endfunction

endpackage

// File: rtl/data_axi_bridge_aw_w_tracker.sv
// Tracks AW and W handshakes of one write so each valid drops on its own.
// Ports: clk, rst_n, active, awready, wready -> awvalid, wvalid, both_done.
module data_axi_bridge_aw_w_tracker (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic both_done
);

  logic aw_done;
  logic w_done;
  logic aw_nxt;
  logic w_nxt;

  assign awvalid = active & ~aw_done;
  assign wvalid  = active & ~w_done;

  // Include the handshakes of this cycle so the completing cycle counts.
  assign aw_nxt    = aw_done | (awvalid & awready);
  assign w_nxt     = w_done  | (wvalid & wready);
  assign both_done = active & aw_nxt & w_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (!active) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= aw_nxt;
      w_done  <= w_nxt;
    end
  end

endmodule

// File: rtl/data_axi_bridge.sv
// SRAM-like MEM-stage request to single-beat AXI3 read/write bridge.
// Ports: CPU req/addr_ok/data_ok side, AXI AR/R/AW/W/B channels.
module data_axi_bridge
  import data_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                req,
  input  logic                wr,
  input  logic [1:0]          size,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   wdata,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [DATA_W-1:0]   rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          size_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                aw_w_done;
  logic                in_aw_w;

  assign araddr = addr_q;
  assign arsize = size_q;
  assign awaddr = addr_q;
  assign awsize = size_q;
  assign w_data = wdata_q;
  assign w_strb = wstrb_q;

  assign in_aw_w = (state == S_AW_W);

  data_axi_bridge_aw_w_tracker u_aw_w (
    .clk       (aclk),
    .rst_n     (aresetn),
    .active    (in_aw_w),
    .awready   (awready),
    .wready    (wready),
    .awvalid   (awvalid),
    .wvalid    (wvalid),
    .both_done (aw_w_done)
  );

  always_comb begin
    state_nxt = state;
    addr_ok   = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    unique case (state)
      S_IDLE: begin
        addr_ok = req;
        if (req) state_nxt = wr ? S_AW_W : S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && rlast) state_nxt = S_IDLE;
      end
      S_AW_W: begin
        wlast = 1'b1;
        if (aw_w_done) state_nxt = S_B;
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      resp_err <= 1'b0;
      data_ok  <= 1'b0;
    end else begin
      state   <= state_nxt;
      data_ok <= 1'b0;
      if (addr_ok) begin
        addr_q  <= addr;
        size_q  <= axsize(size);
        wstrb_q <= wstrb;
        wdata_q <= wdata;
      end
      // A beat without rlast is captured but does not finish the read.
      if (state == S_R && rvalid) begin
        rdata <= r_data;
        if (rlast) begin
          resp_err <= (rresp != OKAY);
          data_ok  <= 1'b1;
        end
      end
      if (state == S_B && bvalid) begin
        resp_err <= (bresp != OKAY);
        data_ok  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_axi_bridge.sv
// Self-checking bench for data_axi_bridge: directed and random transactions.
// Acts as CPU and AXI slave; expectations come from transaction-level rules.
module tb_data_axi_bridge;

  logic        aclk;
  logic        aresetn;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        resp_err;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] r_data;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int errors;
  int checks;

  logic [31:0] last_rd;

  bit          nx_w;
  logic [1:0]  nx_sz;
  logic [31:0] nx_a;
  logic [3:0]  nx_st;
  logic [31:0] nx_wd;

  data_axi_bridge dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .addr     (addr),
    .wstrb    (wstrb),
    .wdata    (wdata),
    .addr_ok  (addr_ok),
    .data_ok  (data_ok),
    .rdata    (rdata),
    .resp_err (resp_err),
    .araddr   (araddr),
    .arsize   (arsize),
    .arvalid  (arvalid),
    .arready  (arready),
    .r_data   (r_data),
    .rresp    (rresp),
    .rlast    (rlast),
    .rvalid   (rvalid),
    .rready   (rready),
    .awaddr   (awaddr),
    .awsize   (awsize),
    .awvalid  (awvalid),
    .awready  (awready),
    .w_data   (w_data),
    .w_strb   (w_strb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // CPU lines while the bridge is busy: either a held next request
  // or random noise that must not disturb the latched transaction.
  task automatic busy_req(input bit hold);
    if (hold) begin
      req   = 1'b1;
      wr    = nx_w;
      size  = nx_sz;
      addr  = nx_a;
      wstrb = nx_st;
      wdata = nx_wd;
    end else begin
      req   = 1'b0;
      wr    = 1'($urandom);
      size  = 2'($urandom);
      addr  = $urandom;
      wstrb = 4'($urandom);
      wdata = $urandom;
    end
  endtask

  // One full transaction. da/dw/dr: idle cycles before the AR (or AW),
  // W, and R (or B) handshakes.
  task automatic run_txn(input bit w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [3:0] st,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic [1:0] rsp, input int da,
                         input int dw, input int dr,
                         input bit skip_acc, input bit hold);
    logic [2:0] esz;
    int n;
    esz = (sz == 2'd3) ? 3'd2 : {1'b0, sz};
    if (!skip_acc) begin
      req   = 1'b1;
      wr    = w;
      size  = sz;
      addr  = a;
      wstrb = st;
      wdata = wd;
      #1;
      chk("addr_ok_idle", addr_ok, 1);
      tick();
    end
    busy_req(hold);
    if (!w) begin
      for (int k = 0; k <= da; k++) begin
        arready = (k == da);
        #1;
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, a);
        chk("arsize", arsize, esz);
        chk("addr_ok_busy", addr_ok, 0);
        chk("awvalid_rd", awvalid, 0);
        tick();
      end
      arready = 1'b0;
      for (int k = 0; k <= dr; k++) begin
        rvalid = (k == dr);
        rlast  = 1'b1;
        r_data = (k == dr) ? rd : $urandom;
        rresp  = rsp;
        #1;
        chk("rready", rready, 1);
        chk("arvalid_r", arvalid, 0);
        chk("data_ok_busy", data_ok, 0);
        tick();
      end
      rvalid = 1'b0;
      r_data = $urandom;
      rresp  = 2'($urandom);
      last_rd = rd;
    end else begin
      n = (da > dw) ? da : dw;
      for (int k = 0; k <= n; k++) begin
        awready = (k == da);
        wready  = (k == dw);
        #1;
        chk("awvalid", awvalid, (k <= da));
        chk("wvalid", wvalid, (k <= dw));
        chk("awaddr", awaddr, a);
        chk("awsize", awsize, esz);
        chk("w_data", w_data, wd);
        chk("w_strb", w_strb, st);
        if (k <= dw) chk("wlast", wlast, 1);
        chk("arvalid_wr", arvalid, 0);
        chk("addr_ok_busy", addr_ok, 0);
        tick();
      end
      awready = 1'b0;
      wready  = 1'b0;
      for (int k = 0; k <= dr; k++) begin
        bvalid = (k == dr);
        bresp  = (k == dr) ? rsp : 2'($urandom);
        #1;
        chk("bready", bready, 1);
        chk("awvalid_b", awvalid, 0);
        chk("wvalid_b", wvalid, 0);
        chk("data_ok_busy", data_ok, 0);
        tick();
      end
      bvalid = 1'b0;
    end
    #1;
    chk("data_ok", data_ok, 1);
    chk("resp_err", resp_err, (rsp != 2'b00));
    chk("rdata", rdata, last_rd);
    chk("addr_ok_done", addr_ok, hold);
    chk("rready_done", rready, 0);
    chk("bready_done", bready, 0);
    tick();
    chk("data_ok_pulse", data_ok, 0);
    chk("rdata_hold", rdata, last_rd);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    last_rd = '0;
    aresetn = 1'b0;
    req     = 1'b0;
    wr      = 1'b0;
    size    = '0;
    addr    = '0;
    wstrb   = '0;
    wdata   = '0;
    arready = 1'b0;
    r_data  = '0;
    rresp   = '0;
    rlast   = 1'b0;
    rvalid  = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bresp   = '0;
    bvalid  = 1'b0;
    #2;
    chk("rst_addr_ok", addr_ok, 0);
    chk("rst_data_ok", data_ok, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 0);
    chk("rst_readys", {rready, bready}, 0);
    chk("rst_araddr", araddr, 0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // word read, minimum latency
    run_txn(0, 2'd2, 32'h1FC0_0010, 4'hF, 32'h0, 32'hDEADBEEF,
            2'b00, 0, 0, 0, 0, 0);

    // byte write, W handshakes two cycles before AW, B two cycles later
    run_txn(1, 2'd0, 32'h0000_0003, 4'b1000, 32'h11223344, 32'h0,
            2'b00, 2, 0, 1, 0, 0);

    // AR backpressure with a second read held until data_ok
    nx_w  = 0;
    nx_sz = 2'd1;
    nx_a  = 32'h8000_0040;
    nx_st = 4'h0;
    nx_wd = 32'h0;
    run_txn(0, 2'd2, 32'h0000_1000, 4'h0, 32'h0, 32'hCAFEF00D,
            2'b00, 4, 0, 0, 0, 1);
    run_txn(0, 2'd1, 32'h8000_0040, 4'h0, 32'h0, 32'h0000_BEEF,
            2'b00, 0, 0, 1, 1, 0);

    // error write response, then an OKAY read
    run_txn(1, 2'd2, 32'h0000_2000, 4'hF, 32'hA5A5A5A5, 32'h0,
            2'b10, 0, 0, 0, 0, 0);
    run_txn(0, 2'd2, 32'h0000_2000, 4'h0, 32'h0, 32'h12345678,
            2'b00, 0, 0, 0, 0, 0);

    // size 3 read clamps to a word
    run_txn(0, 2'd3, 32'h0000_3004, 4'h0, 32'h0, 32'h0BADCAFE,
            2'b00, 1, 0, 0, 0, 0);

    // asynchronous reset while in R
    req  = 1'b1;
    wr   = 1'b0;
    size = 2'd2;
    addr = 32'h0000_4000;
    #1;
    chk("rr_addr_ok", addr_ok, 1);
    tick();
    req     = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    chk("rr_in_r", rready, 1);
    aresetn = 1'b0;
    #1;
    chk("rr_rready", rready, 0);
    chk("rr_arvalid", arvalid, 0);
    chk("rr_data_ok", data_ok, 0);
    chk("rr_rdata", rdata, 0);
    last_rd = '0;
    tick();
    aresetn = 1'b1;
    req     = 1'b1;
    #1;
    chk("rr_addr_ok_req", addr_ok, 1);
    req = 1'b0;
    #1;
    chk("rr_addr_ok_noreq", addr_ok, 0);
    tick();

    // random traffic
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), 2'($urandom), $urandom, 4'($urandom),
              $urandom, $urandom, 2'($urandom),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
